// File: rtl/legv8_pkg.sv
// Shared LEGv8 write-back constants.
// Used by the register file and its read ports.
package legv8_pkg;
  localparam int DATA_W    = 64;
  localparam int REG_IDX_W = 5;
  localparam int XZR_IDX   = 31;
  localparam int INSTR_W   = 32;
endpackage

// File: rtl/regfile_bypass_rd.sv
// One combinational register-file read port.
// XZR reads zero; a committing write is bypassed to the reader.
module regfile_bypass_rd
  import legv8_pkg::*;
#(
  parameter int DW = 64,
  parameter int NR = 32
) (
  input  logic [REG_IDX_W-1:0] i_idx,
  input  logic                 i_wr_en,
  input  logic [REG_IDX_W-1:0] i_wr_idx,
  input  logic [DW-1:0]        i_wr_data,
  input  logic [DW-1:0]        i_regs [NR],
  output logic [DW-1:0]        o_data
);

  logic w_is_xzr;
  logic w_hit;

  assign w_is_xzr = (i_idx == REG_IDX_W'(XZR_IDX));
  assign w_hit    = i_wr_en && (i_idx == i_wr_idx);

  always_comb begin
    o_data = i_regs[i_idx];
    if (w_is_xzr)
      o_data = '0;
    else if (w_hit)
      o_data = i_wr_data;
  end

endmodule

// File: rtl/wb_regfile.sv
// MEM/WB write-back and 32 x 64-bit LEGv8 register file.
// Two bypassed read ports, commit counter and last-write record.
module wb_regfile
  import legv8_pkg::*;
#(
  parameter int DATA_W = legv8_pkg::DATA_W,
  parameter int NREGS  = 32,
  parameter int CNT_W  = 32
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [DATA_W-1:0]               Read_data,
  input  logic [DATA_W-1:0]               Alu_result,
  input  logic [legv8_pkg::REG_IDX_W-1:0] Write_reg,
  input  logic                            RegWrite,
  input  logic                            MemtoReg,
  input  logic [legv8_pkg::INSTR_W-1:0]   Instruction_mem_wb,
  input  logic [legv8_pkg::REG_IDX_W-1:0] read_reg1,
  input  logic [legv8_pkg::REG_IDX_W-1:0] read_reg2,
  output logic [DATA_W-1:0]               read_data1,
  output logic [DATA_W-1:0]               read_data2,
  output logic [DATA_W-1:0]               wb_data,
  output logic                            wb_commit,
  output logic [CNT_W-1:0]                commit_count,
  output logic [legv8_pkg::REG_IDX_W-1:0] last_wr_reg,
  output logic [legv8_pkg::INSTR_W-1:0]   last_instr
);

  logic [DATA_W-1:0]    r_regs [NREGS];
  logic [CNT_W-1:0]     r_count;
  logic [REG_IDX_W-1:0] r_last_reg;
  logic [INSTR_W-1:0]   r_last_instr;
  logic [DATA_W-1:0]    w_wb_data;
  logic                 w_commit;

  assign w_wb_data = MemtoReg ? Read_data : Alu_result;
  assign w_commit  = RegWrite &&
                     (Write_reg != REG_IDX_W'(XZR_IDX));

  // Entry XZR exists only to keep indexing in range; never written.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
      r_count      <= '0;
      r_last_reg   <= '0;
      r_last_instr <= '0;
    end else if (w_commit) begin
      r_regs[Write_reg] <= w_wb_data;
      r_count           <= r_count + CNT_W'(1);
      r_last_reg        <= Write_reg;
      r_last_instr      <= Instruction_mem_wb;
    end
  end

  regfile_bypass_rd #(
    .DW (DATA_W),
    .NR (NREGS)
  ) u_rd1 (
    .i_idx     (read_reg1),
    .i_wr_en   (w_commit),
    .i_wr_idx  (Write_reg),
    .i_wr_data (w_wb_data),
    .i_regs    (r_regs),
    .o_data    (read_data1)
  );

  regfile_bypass_rd #(
    .DW (DATA_W),
    .NR (NREGS)
  ) u_rd2 (
    .i_idx     (read_reg2),
    .i_wr_en   (w_commit),
    .i_wr_idx  (Write_reg),
    .i_wr_data (w_wb_data),
    .i_regs    (r_regs),
    .o_data    (read_data2)
  );

  assign wb_data      = w_wb_data;
  assign wb_commit    = w_commit;
  assign commit_count = r_count;
  assign last_wr_reg  = r_last_reg;
  assign last_instr   = r_last_instr;

endmodule
